// File: rtl/hazard_scoreboard.sv
// Register-pipeline hazard scoreboard: per-GPR pending/Tnew/age tracking, stall and forwarding select.
// Optional multiply/divide busy tracking is built only when macro HAZ_MD_EN is defined.
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int RW      = 5,
  parameter int TW      = 2,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_D,
  input  logic [RW-1:0] rs_D,
  input  logic [RW-1:0] rt_D,
  input  logic          use_rs_D,
  input  logic          use_rt_D,
  input  logic [TW-1:0] tuse_rs_D,
  input  logic [TW-1:0] tuse_rt_D,
  input  logic          we_D,
  input  logic [RW-1:0] wa_D,
  input  logic [TW-1:0] tnew_D,
  input  logic          md_D,
  input  logic          md_start_E,
  input  logic          md_div_E,
  output logic          stall,
  output logic [1:0]    fwd_rs_sel,
  output logic [1:0]    fwd_rt_sel,
  output logic          md_busy
);

  logic [NREG-1:0] pend_r;
  logic [TW-1:0]   tnew_r [NREG];
  logic [1:0]      age_r  [NREG];

  logic issue_s;
  logic rs_pend_s;
  logic rt_pend_s;
  logic haz_rs_s;
  logic haz_rt_s;
  logic md_stall_s;

  assign issue_s = valid_D && !stall && we_D && (wa_D != {RW{1'b0}});

  // Scoreboard entries: load on issue (wins over retirement), otherwise age and retire after W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        pend_r[i] <= 1'b0;
        tnew_r[i] <= {TW{1'b0}};
        age_r[i]  <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i == 0) begin
          pend_r[i] <= 1'b0;
          tnew_r[i] <= {TW{1'b0}};
          age_r[i]  <= 2'd0;
        end else if (issue_s && (wa_D == RW'(i))) begin
          pend_r[i] <= 1'b1;
          tnew_r[i] <= tnew_D;
          age_r[i]  <= 2'd0;
        end else if (pend_r[i]) begin
          if (age_r[i] == 2'd2) begin
            pend_r[i] <= 1'b0;
            age_r[i]  <= 2'd0;
          end else begin
            age_r[i]  <= age_r[i] + 2'd1;
          end
          if (tnew_r[i] != {TW{1'b0}}) begin
            tnew_r[i] <= tnew_r[i] - {{(TW-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

  assign rs_pend_s = (rs_D != {RW{1'b0}}) && pend_r[rs_D];
  assign rt_pend_s = (rt_D != {RW{1'b0}}) && pend_r[rt_D];
  assign haz_rs_s  = valid_D && use_rs_D && rs_pend_s && (tuse_rs_D < tnew_r[rs_D]);
  assign haz_rt_s  = valid_D && use_rt_D && rt_pend_s && (tuse_rt_D < tnew_r[rt_D]);

`ifdef HAZ_MD_EN
  localparam int MAXC = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] md_cnt_r;

  // Busy countdown; a new start always reloads, even mid-operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_r <= {CW{1'b0}};
    end else if (md_start_E) begin
      md_cnt_r <= md_div_E ? CW'(DIV_CYC) : CW'(MUL_CYC);
    end else if (md_cnt_r != {CW{1'b0}}) begin
      md_cnt_r <= md_cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign md_busy    = md_start_E || (md_cnt_r != {CW{1'b0}});
  assign md_stall_s = valid_D && md_D && md_busy;
`else
  logic unused_md_s;
  assign unused_md_s = ^{md_D, md_start_E, md_div_E};
  assign md_busy     = 1'b0;
  assign md_stall_s  = 1'b0;
`endif

  // Stall and forwarding selects; forced quiet while reset is held.
  always_comb begin
    stall      = 1'b0;
    fwd_rs_sel = 2'd0;
    fwd_rt_sel = 2'd0;
    if (reset) begin
      stall      = 1'b0;
      fwd_rs_sel = 2'd0;
      fwd_rt_sel = 2'd0;
    end else begin
      stall = haz_rs_s || haz_rt_s || md_stall_s;
      if (rs_pend_s) begin
        fwd_rs_sel = age_r[rs_D] + 2'd1;
      end else begin
        fwd_rs_sel = 2'd0;
      end
      if (rt_pend_s) begin
        fwd_rt_sel = age_r[rt_D] + 2'd1;
      end else begin
        fwd_rt_sel = 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a cycle-indexed reference model queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_scoreboard;

  localparam int MULC = 5;
  localparam int DIVC = 10;

  logic       clk;
  logic       reset;
  logic       valid_D;
  logic [4:0] rs_D, rt_D;
  logic       use_rs_D, use_rt_D;
  logic [1:0] tuse_rs_D, tuse_rt_D;
  logic       we_D;
  logic [4:0] wa_D;
  logic [1:0] tnew_D;
  logic       md_D, md_start_E, md_div_E;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic       md_busy;

  hazard_scoreboard #(.NREG(32), .RW(5), .TW(2), .MUL_CYC(MULC), .DIV_CYC(DIVC)) dut (
    .clk(clk), .reset(reset), .valid_D(valid_D),
    .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .we_D(we_D), .wa_D(wa_D), .tnew_D(tnew_D),
    .md_D(md_D), .md_start_E(md_start_E), .md_div_E(md_div_E),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [1:0] trs, trt;
    logic       we;
    logic [4:0] wa;
    logic [1:0] tn;
    logic       md, ms, mdiv;
  } stim_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       busy;
    logic       chk_rs;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: an entry is described by the cycle it issued and its Tnew at issue.
  int cyc = 0;
  int iss [32];
  int tn0 [32];
  int md_s;
  int md_len;

  function automatic void clear_model();
    for (int i = 0; i < 32; i++) begin
      iss[i] = -1000;
      tn0[i] = 0;
    end
    md_s   = -1000;
    md_len = 0;
  endfunction

  function automatic int m_age(int r);
    return cyc - iss[r] - 1;
  endfunction

  function automatic bit m_pend(int r);
    return (r != 0) && (m_age(r) >= 0) && (m_age(r) <= 2);
  endfunction

  function automatic int m_tnew(int r);
    int t;
    t = tn0[r] - m_age(r);
    return (t < 0) ? 0 : t;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t wr(int r, int t);
    stim_t s;
    s = nop();
    s.v = 1'b1; s.we = 1'b1; s.wa = 5'(r); s.tn = 2'(t);
    return s;
  endfunction

  function automatic stim_t rd(int r, int tu);
    stim_t s;
    s = nop();
    s.v = 1'b1; s.urs = 1'b1; s.rs = 5'(r); s.trs = 2'(tu);
    return s;
  endfunction

  // xs: -1 = model stall, else explicit. xrs: -1 = model, -2 = unchecked, else explicit.
  task automatic step(input stim_t s, input int xs, input int xrs);
    exp_t e;
    bit hr, ht, mb, ms_eff;
    @(posedge clk);
    #1;
    reset = s.rst; valid_D = s.v; rs_D = s.rs; rt_D = s.rt;
    use_rs_D = s.urs; use_rt_D = s.urt; tuse_rs_D = s.trs; tuse_rt_D = s.trt;
    we_D = s.we; wa_D = s.wa; tnew_D = s.tn;
    md_D = s.md; md_start_E = s.ms; md_div_E = s.mdiv;
    if (s.rst) clear_model();
`ifdef HAZ_MD_EN
    ms_eff = s.ms;
    mb = s.ms || ((cyc - md_s >= 1) && (cyc - md_s <= md_len));
`else
    ms_eff = 1'b0;
    mb = 1'b0;
`endif
    hr = s.v && s.urs && m_pend(int'(s.rs)) && (int'(s.trs) < m_tnew(int'(s.rs)));
    ht = s.v && s.urt && m_pend(int'(s.rt)) && (int'(s.trt) < m_tnew(int'(s.rt)));
    e.stall  = !s.rst && (hr || ht || (s.v && s.md && mb));
    e.rs     = (!s.rst && m_pend(int'(s.rs))) ? 2'(m_age(int'(s.rs)) + 1) : 2'd0;
    e.rt     = (!s.rst && m_pend(int'(s.rt))) ? 2'(m_age(int'(s.rt)) + 1) : 2'd0;
    e.busy   = mb;
    e.chk_rs = 1'b1;
    e.cyc    = 32'(cyc);
    if (!s.rst && s.v && !e.stall && s.we && s.wa != 5'd0) begin
      iss[s.wa] = cyc;
      tn0[s.wa] = int'(s.tn);
    end
    if (!s.rst && ms_eff) begin
      md_s   = cyc;
      md_len = s.mdiv ? DIVC : MULC;
    end
    if (xs >= 0) e.stall = (xs != 0);
    if (xrs == -2) e.chk_rs = 1'b0;
    else if (xrs >= 0) e.rs = 2'(xrs);
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(nop(), -1, -1);
  endtask

  // Monitor: outputs are settled mid-cycle; compare against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (stall !== e.stall) begin
          bad++;
          $display("FAIL stall cyc=%0d got=%b want=%b", e.cyc, stall, e.stall);
        end
        if (e.chk_rs) begin
          total++;
          if (fwd_rs_sel !== e.rs) begin
            bad++;
            $display("FAIL fwd_rs_sel cyc=%0d got=%0d want=%0d", e.cyc, fwd_rs_sel, e.rs);
          end
        end
        total++;
        if (fwd_rt_sel !== e.rt) begin
          bad++;
          $display("FAIL fwd_rt_sel cyc=%0d got=%0d want=%0d", e.cyc, fwd_rt_sel, e.rt);
        end
        total++;
        if (md_busy !== e.busy) begin
          bad++;
          $display("FAIL md_busy cyc=%0d got=%b want=%b", e.cyc, md_busy, e.busy);
        end
      end
    end
  end

  initial begin
    stim_t s;
    clear_model();
    reset = 1'b1; valid_D = 1'b0; rs_D = 5'd0; rt_D = 5'd0;
    use_rs_D = 1'b0; use_rt_D = 1'b0; tuse_rs_D = 2'd0; tuse_rt_D = 2'd0;
    we_D = 1'b0; wa_D = 5'd0; tnew_D = 2'd0;
    md_D = 1'b0; md_start_E = 1'b0; md_div_E = 1'b0;

    // Reset state
    s = nop(); s.rst = 1'b1;
    step(s, 0, 0);
    step(s, 0, 0);
    idle(2);

    // addu $3 then beq on $3 with tuse 0
    step(wr(3, 1), 0, 0);
    step(rd(3, 0), 1, -2);
    step(rd(3, 0), 0, 2);
    idle(4);

    // lw $2 then addu rs=$2, tuse 1 and tuse 2
    step(wr(2, 2), 0, 0);
    step(rd(2, 1), 1, -2);
    step(rd(2, 1), 0, 2);
    idle(4);
    step(wr(2, 2), 0, 0);
    step(rd(2, 2), 0, 1);
    idle(4);

    // lw $0 never creates a hazard
    step(wr(0, 2), 0, 0);
    step(rd(0, 0), 0, 0);
    idle(4);

    // $5 reissued while its old entry sits at age 2
    step(wr(5, 0), 0, 0);
    step(rd(5, 0), 0, 1);
    step(rd(5, 0), 0, 2);
    s = wr(5, 0); s.urs = 1'b1; s.rs = 5'd5;
    step(s, 0, 3);
    step(rd(5, 0), 0, 1);
    step(rd(5, 0), 0, 2);
    step(rd(5, 0), 0, 3);
    step(rd(5, 0), 0, 0);
    idle(2);

    // Reset mid-run with a live hazard pending
    step(wr(7, 3), 0, 0);
    s = rd(7, 0); s.rst = 1'b1;
    step(s, 0, 0);
    step(rd(7, 0), 0, 0);
    idle(2);

    // Multiply/divide busy stalls
    s = nop(); s.v = 1'b1; s.md = 1'b1;
`ifdef HAZ_MD_EN
    s.ms = 1'b1; s.mdiv = 1'b0;
    step(s, 1, 0);
    s.ms = 1'b0;
    for (int i = 0; i < MULC; i++) step(s, 1, 0);
    step(s, 0, 0);
    idle(2);
    s.ms = 1'b1; s.mdiv = 1'b1;
    step(s, 1, 0);
    s.ms = 1'b0; s.mdiv = 1'b0;
    for (int i = 0; i < DIVC; i++) step(s, 1, 0);
    step(s, 0, 0);
    idle(2);
    s.ms = 1'b1;
    step(s, 1, 0);
    s.ms = 1'b0;
    step(s, 1, 0);
    s.rst = 1'b1;
    step(s, 0, 0);
    s.rst = 1'b0;
    step(s, 0, 0);
    idle(12);
`else
    s.ms = 1'b1; s.mdiv = 1'b1;
    step(s, 0, 0);
    s.ms = 1'b0;
    step(s, 0, 0);
    idle(2);
`endif

    // Randomized traffic on a small register window to provoke dependencies
    for (int n = 0; n < 3000; n++) begin
      s = nop();
      s.rst  = ($urandom_range(0, 59) == 0);
      s.v    = ($urandom_range(0, 3) != 0);
      s.rs   = 5'($urandom_range(0, 6));
      s.rt   = 5'($urandom_range(0, 6));
      s.urs  = 1'($urandom_range(0, 1));
      s.urt  = 1'($urandom_range(0, 1));
      s.trs  = 2'($urandom_range(0, 3));
      s.trt  = 2'($urandom_range(0, 3));
      s.we   = ($urandom_range(0, 2) != 0);
      s.wa   = 5'($urandom_range(0, 6));
      s.tn   = 2'($urandom_range(0, 3));
      s.md   = ($urandom_range(0, 5) == 0);
      s.ms   = ($urandom_range(0, 11) == 0);
      s.mdiv = 1'($urandom_range(0, 1));
      step(s, -1, -1);
    end

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameters, one per line:
- NREG, 32, architectural register count (register 0 hard-wired zero)
- RW, 5, register address width
- TW, 2, Tnew/Tuse field width
- MUL_CYC, 5, mult/multu busy cycles
- DIV_CYC, 10, div/divu busy cycles
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- valid_D  in  1  D-stage holds a real instruction
- rs_D / rt_D  in  RW  D-stage source registers
- use_rs_D / use_rt_D  in  1  source is actually read
- tuse_rs_D / tuse_rt_D  in  TW  cycles until the operand is needed
- we_D  in  1  instruction writes a GPR
- wa_D  in  RW  destination register
- tnew_D  in  TW  Tnew the instruction will have on entering E
- md_D  in  1  D-stage is mult/div/mfhi/mflo/mthi/mtlo
- md_start_E  in  1  mult/div start pulse from E
- md_div_E  in  1  qualifies md_start_E: 1 = div, 0 = mult
- stall  out  1  freeze F/D, inject bubble into E
- fwd_rs_sel / fwd_rt_sel  out  2  0 = GRF, 1 = E, 2 = M, 3 = W
- md_busy  out  1  multiply/divide unit busy

Function
REQ-003 SHALL keep one entry per register 1..NREG-1 holding pend (1b), tnew (TW), age (2b: 0 = E, 1 = M, 2 = W).
REQ-004 SHALL set the issue condition each cycle as valid_D && !stall && we_D && wa_D != 0.
REQ-005 When the issue condition holds, SHALL load entry[wa_D] at the next edge with pend=1, tnew=tnew_D, age=0.
REQ-006 Every other pending entry SHALL advance each edge: tnew decrements, saturating at 0; age increments.
REQ-007 A pending entry with age 2 SHALL clear pend at the next edge.
REQ-008 An issue to the same register in that same cycle SHALL take priority over the clear.
REQ-009 Entry for register 0 SHALL never be pending, and writes to it SHALL be ignored.
REQ-010 The rs hazard SHALL be: valid_D && use_rs_D && rs_D != 0 && pend[rs_D] && tuse_rs_D < tnew[rs_D]. The rt hazard is identical with rt signals.
REQ-011 stall SHALL be combinational: rs hazard | rt hazard | md_stall.
REQ-012 fwd_rs_sel SHALL equal age[rs_D]+1 when pend[rs_D] && rs_D != 0, and 0 otherwise. fwd_rt_sel follows the same rule. Both are valid only when stall = 0.
REQ-013 SHALL keep an MD busy counter. On md_start_E it loads DIV_CYC when md_div_E = 1, else MUL_CYC, effective next edge. Otherwise it decrements while nonzero.
REQ-014 md_busy SHALL equal md_start_E || counter != 0.
REQ-015 md_stall SHALL equal valid_D && md_D && md_busy.
REQ-016 A mult followed directly by mflo SHALL stall exactly 1 + MUL_CYC cycles.
REQ-017 A start arriving while the counter is nonzero SHALL reload the counter.

Reset
REQ-018 Asserting reset at any time SHALL asynchronously clear every pend, tnew and age field and the MD counter.
REQ-019 While reset is asserted, outputs SHALL be: stall = 0, fwd_*_sel = 0, md_busy = md_start_E (combinational only).
REQ-020 Reset during an MD operation SHALL drop md_busy on the same cycle, absent a start.

Configuration
REQ-021 With macro HAZ_MD_EN defined, REQ-013..REQ-017 and REQ-020 SHALL be built.
REQ-022 Without HAZ_MD_EN, the MD counter SHALL not exist, md_busy and md_stall SHALL be tied 0, and md_D, md_start_E and md_div_E SHALL be ignored.

Verification
REQ-023 Reset pulse mid-run -> all entries clear; stall = 0, fwd sels = 0, md_busy = 0 the same cycle.
REQ-024 Issue addu $3 (tnew=1); next D: beq rs=$3, tuse=0 -> stall = 1 for 1 cycle, then stall = 0 with fwd_rs_sel = 2.
REQ-025 Issue lw $2 (tnew=2); next D: addu rs=$2, tuse=1 -> stall 1 cycle, then fwd_rs_sel = 2; with tuse=2 -> no stall, fwd_rs_sel = 1.
REQ-026 Issue lw $0 (tnew=2); next D: rs=$0, tuse=0 -> stall = 0, fwd_rs_sel = 0.
REQ-027 $5 entry at age 2 while a new write to $5 issues -> entry reloads with age 0; the following cycle gives fwd sel = 1, not 0.
REQ-028 HAZ_MD_EN: md_start_E with md_div_E = 0, then mflo held in D -> stall for 6 cycles. With md_div_E = 1 -> stall for 11 cycles. Reset asserted at the 3rd stalled cycle -> stall drops immediately.
